// File: rtl/crem_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : crem_uart_pkg                                          |
// | Description : Shared definitions for the CREM FIFO-fed UART          |
// |               transmitter: FSM state encoding, parity-type           |
// |               constants and the parity helper.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package crem_uart_pkg;

    // Transmit frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity-type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit from the XOR-reduction of the data word and the parity type.
    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic calc_parity(input logic data_xor, input logic typ);
        logic v_bit;
        unique case (typ)
            PAR_EVEN: v_bit = data_xor;
            PAR_ODD:  v_bit = ~data_xor;
        endcase
        return v_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_tx_bit_timer                                      |
// | Description : Serial bit-period timer. Counts 0..CLKS_PER_BIT-1      |
// |               while run is high and pulses bit_done for one cycle    |
// |               at terminal count. Held at zero while run is low.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic r_clk,
    input  logic r_rst,
    input  logic run,
    output logic bit_done
);

    // CLKS_PER_BIT >= 2, so the counter is always at least one bit wide
    localparam int                c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_term  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_done;

    assign w_done   = run && (r_cnt == c_term);
    assign bit_done = w_done;

    // Period counter: clears when stopped or when a bit completes
    always_ff @(posedge r_clk) begin
        if (r_rst || !run || w_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_uart_tx                                           |
// | Description : Read-side consumer of the CREM async FIFO. Pops one    |
// |               word per frame and serialises it as start, data (LSB   |
// |               first), optional parity and stop bits. Runs in the     |
// |               FIFO read clock domain.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_uart_tx
    import crem_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  r_inc,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int                 c_idx_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_WIDTH - 1);

    // Registered state
    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_idx_w-1:0]    r_bit_idx;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_pop;
    logic                  r_tx;
    logic                  r_busy;

    // Next-state values
    tx_state_e             w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [c_idx_w-1:0]    w_idx_nxt;
    logic                  w_par_en_nxt;
    logic                  w_par_bit_nxt;
    logic                  w_pop_nxt;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_frame_start;
    logic                  w_bit_done;
    logic                  w_timer_run;

    // The timer runs for every cycle the line carries a frame
    assign w_timer_run = (r_state != ST_IDLE);

    uart_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .r_clk    (r_clk),
        .r_rst    (r_rst),
        .run      (w_timer_run),
        .bit_done (w_bit_done)
    );

    // Next-state and output decode; frame start overrides the per-state result
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_bit_idx;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_pop_nxt     = 1'b0;
        w_tx_nxt      = r_tx;
        w_frame_start = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!empty) begin
                    w_frame_start = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    // Present data bit 0; keep the remaining bits pre-shifted
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == c_last_idx) begin
                        if (r_par_en) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_idx_nxt   = r_bit_idx + c_idx_w'(1);
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    // Empty is re-checked only here, long after the last pop,
                    // so lag in the FIFO's empty flag is harmless
                    if (!empty) begin
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Frame start: capture the head word and parity settings, pop once,
        // and drive the start bit on this same edge
        if (w_frame_start) begin
            w_state_nxt   = ST_START;
            w_shift_nxt   = rd_data;
            w_idx_nxt     = '0;
            w_par_en_nxt  = par_en;
            w_par_bit_nxt = calc_parity(^rd_data, par_typ);
            w_pop_nxt     = 1'b1;
            w_tx_nxt      = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_pop     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_idx_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_pop     <= w_pop_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign r_inc  = r_pop;
    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fifo_uart_tx                                        |
// | Description : Scoreboard bench for fifo_uart_tx. Stimulus pushes the |
// |               expected frame; a line monitor decodes tx_out and      |
// |               compares it bit by bit.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       pen;
        logic       pbit;
    } exp_t;

    logic       r_clk   = 1'b0;
    logic       r_rst   = 1'b1;
    logic       empty   = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       par_en  = 1'b0;
    logic       par_typ = 1'b0;
    logic       r_inc;
    logic       tx_out;
    logic       busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] junk = 8'h00;
    exp_t exp_q[$];
    int   inc_times[$];
    int   busy_cnt   = 0;
    int   busy_rises = 0;
    logic busy_prev  = 1'b0;
    bit   mon_idle   = 1'b1;

    fifo_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .r_clk   (r_clk),
        .r_rst   (r_rst),
        .empty   (empty),
        .rd_data (rd_data),
        .par_en  (par_en),
        .par_typ (par_typ),
        .r_inc   (r_inc),
        .tx_out  (tx_out),
        .busy    (busy)
    );

    always #5 r_clk = ~r_clk;

    // FIFO read-port model: pop on r_inc, registered empty/head update
    always @(posedge r_clk) begin
        cyc = cyc + 1;
        if (r_inc === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        #1;
        empty   = (fifo_q.size() == 0);
        rd_data = empty ? junk : fifo_q[0];
    end

    // Pop and busy statistics
    always @(negedge r_clk) begin
        if (r_inc === 1'b1) inc_times.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
        busy_prev = busy;
    end

    // Line monitor: decodes each frame and checks every bit period
    initial begin : monitor
        exp_t       e;
        logic [10:0] fb;
        int         nb;
        bit         abort;
        bit         berr;
        logic       got_tx;
        logic       got_busy;
        int         fnum;
        int         guard;
        fnum = 0;
        forever begin
            @(negedge r_clk);
            if (r_rst !== 1'b0 || tx_out !== 1'b0) continue;
            mon_idle = 1'b0;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: tx_out=0 at cycle %0d with nothing expected", cyc);
                guard = 0;
                while (tx_out !== 1'b1 && guard < 1000) begin
                    @(negedge r_clk);
                    guard++;
                end
                mon_idle = 1'b1;
                continue;
            end
            e  = exp_q.pop_front();
            fb = '1;
            fb[0]   = 1'b0;
            fb[8:1] = e.data;
            if (e.pen) begin
                fb[9]  = e.pbit;
                fb[10] = 1'b1;
                nb     = 11;
            end else begin
                fb[9] = 1'b1;
                nb    = 10;
            end
            abort = 1'b0;
            for (int b = 0; b < nb && !abort; b++) begin
                berr     = 1'b0;
                got_tx   = fb[b];
                got_busy = 1'b1;
                for (int c = 0; c < CPB && !abort; c++) begin
                    if (b != 0 || c != 0) begin
                        @(negedge r_clk);
                        if (r_rst !== 1'b0) abort = 1'b1;
                    end
                    if (!abort && (tx_out !== fb[b] || busy !== 1'b1)) begin
                        berr     = 1'b1;
                        got_tx   = tx_out;
                        got_busy = busy;
                    end
                end
                if (!abort) begin
                    total++;
                    if (berr) begin
                        bad++;
                        $display("FAIL frame%0d_bit%0d: tx_out=%b busy=%b, want tx_out=%b busy=1",
                                 fnum, b, got_tx, got_busy, fb[b]);
                    end
                end
            end
            fnum++;
            mon_idle = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge r_clk);
        #2;
    endtask

    task automatic clear_stats();
        inc_times.delete();
        busy_cnt   = 0;
        busy_rises = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && busy === 1'b0 && mon_idle && exp_q.size() == 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, n);
        end
        step();
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tx_out !== 1'b0 && n < 200);
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_start_timeout: no start bit within %0d cycles", name, n);
        end
    endtask

    // Stimulus
    initial begin : stim
        int idle_bad;

        // Reset and idle
        r_rst = 1'b1;
        repeat (3) step();
        chk("reset_tx_out", int'(tx_out), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_r_inc", int'(r_inc), 0);
        r_rst = 1'b0;
        clear_stats();
        idle_bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx_out !== 1'b1 || busy !== 1'b0 || r_inc !== 1'b0) idle_bad++;
        end
        chk("idle_hold_bad_cycles", idle_bad, 0);
        chk("idle_pops", inc_times.size(), 0);

        // Single byte, no parity
        clear_stats();
        par_en = 1'b0;
        exp_q.push_back('{8'hF1, 1'b0, 1'b0});
        fifo_q.push_back(8'hF1);
        wait_done("single");
        chk("single_pops", inc_times.size(), 1);
        chk("single_busy_cycles", busy_cnt, 40);
        chk("single_busy_rises", busy_rises, 1);

        // Even parity: 0xF1 has five ones -> parity 1
        clear_stats();
        par_en  = 1'b1;
        par_typ = 1'b0;
        exp_q.push_back('{8'hF1, 1'b1, 1'b1});
        fifo_q.push_back(8'hF1);
        wait_done("par_even");
        chk("par_even_busy_cycles", busy_cnt, 44);

        // Odd parity -> parity 0
        clear_stats();
        par_typ = 1'b1;
        exp_q.push_back('{8'hF1, 1'b1, 1'b0});
        fifo_q.push_back(8'hF1);
        wait_done("par_odd");
        chk("par_odd_busy_cycles", busy_cnt, 44);

        // Burst of three back-to-back frames
        clear_stats();
        par_en  = 1'b0;
        par_typ = 1'b0;
        exp_q.push_back('{8'hF1, 1'b0, 1'b0});
        exp_q.push_back('{8'hF9, 1'b0, 1'b0});
        exp_q.push_back('{8'hF5, 1'b0, 1'b0});
        fifo_q.push_back(8'hF1);
        fifo_q.push_back(8'hF9);
        fifo_q.push_back(8'hF5);
        wait_done("burst");
        chk("burst_pops", inc_times.size(), 3);
        if (inc_times.size() == 3) begin
            chk("burst_pop_gap0", inc_times[1] - inc_times[0], 40);
            chk("burst_pop_gap1", inc_times[2] - inc_times[1], 40);
        end
        chk("burst_busy_cycles", busy_cnt, 120);
        chk("burst_busy_rises", busy_rises, 1);

        // Mid-frame changes to par_en, par_typ and rd_data are ignored.
        // 0xF9 has six ones -> even parity bit 0
        clear_stats();
        par_en  = 1'b1;
        par_typ = 1'b0;
        exp_q.push_back('{8'hF9, 1'b1, 1'b0});
        fifo_q.push_back(8'hF9);
        wait_start("midchg");
        repeat (10) step();
        par_en  = 1'b0;
        par_typ = 1'b1;
        junk    = 8'hA5;
        repeat (8) step();
        junk    = 8'h5A;
        par_en  = 1'b1;
        wait_done("midchg");
        chk("midchg_busy_cycles", busy_cnt, 44);
        chk("midchg_pops", inc_times.size(), 1);
        par_en  = 1'b0;
        par_typ = 1'b0;
        junk    = 8'h00;
        repeat (3) step();

        // Reset during data bit 3, with the next byte already waiting
        clear_stats();
        exp_q.push_back('{8'h3C, 1'b0, 1'b0});
        fifo_q.push_back(8'h3C);
        wait_start("rst_mid");
        repeat (16) step();
        fifo_q.push_back(8'h5A);
        exp_q.push_back('{8'h5A, 1'b0, 1'b0});
        step();
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        chk("rst_mid_tx_out", int'(tx_out), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_r_inc", int'(r_inc), 0);
        step();
        chk("rst_restart_tx_out", int'(tx_out), 0);
        chk("rst_restart_busy", int'(busy), 1);
        chk("rst_restart_r_inc", int'(r_inc), 1);
        wait_done("rst_mid");
        chk("rst_mid_pops", inc_times.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer of the CREM asynchronous FIFO. Pops one byte at a time from the FIFO's read port and serialises it as a UART frame. Each frame is one start bit, DATA_WIDTH data bits LSB first, an optional parity bit and one stop bit. Runs entirely in the FIFO read clock domain and drives the FIFO's `r_inc`.

## Interface

Parameters:
- DATA_WIDTH, 8, byte width; matches the FIFO DATA_WIDTH.
- CLKS_PER_BIT, 16, r_clk cycles per serial bit; legal range ≥ 2.

Ports:
- r_clk  in  1  read-domain clock. One clock only.
- r_rst  in  1  reset, synchronous, active-high.
- empty  in  1  FIFO empty flag, registered in the r_clk domain.
- rd_data  in  DATA_WIDTH  FIFO head word. Valid whenever empty=0.
- par_en  in  1  1 = append parity bit. Sampled at frame start.
- par_typ  in  1  0 = even, 1 = odd. Sampled at frame start.
- r_inc  out  1  pop strobe to the FIFO, registered.
- tx_out  out  1  serial line, registered, idle high.
- busy  out  1  high from frame start through the last stop-bit cycle.

## Operation

- Reset values: tx_out=1, busy=0, r_inc=0, state=IDLE, bit timer=0.
- States:
  - IDLE → START when empty=0.
  - START → DATA.
  - DATA → DATA until bit index DATA_WIDTH-1 completes, then → PARITY if par_en was latched as 1, else → STOP.
  - PARITY → STOP.
  - STOP → START if empty=0 at stop completion, else → IDLE.
- Frame start (entering START from IDLE or STOP), on that same edge:
  - shift register ← rd_data
  - latch par_en and par_typ
  - r_inc ← 1
  - tx_out ← 0
  - busy ← 1
- r_inc is high for exactly one r_clk cycle per frame. Zero pops when empty=0 is never seen.
- Data bits: tx_out = shift[0], shift right once per completed bit.
- Parity bit = XOR of the latched byte, then XOR par_typ. Even parity gives an even number of ones across data plus parity.
- Stop bit: tx_out=1.
- par_en and par_typ changes mid-frame are ignored.
- rd_data changes after the frame-start edge are ignored.
- Bit timer counts 0..CLKS_PER_BIT-1. Terminal count ends the bit and resets the timer to 0.

## Timing

- Frame-start latency: empty observed 0 at edge k → tx_out=0, busy=1, r_inc=1 from edge k. The FIFO consumes the pop at edge k+1.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is (10 + par_en) × CLKS_PER_BIT cycles for DATA_WIDTH=8.
- Back-to-back frames: the next start bit begins on the edge that ends the stop bit. There is no idle gap, and busy stays 1.
- Empty-flag lag after the pop is tolerated, because the FSM re-checks empty only at stop completion, ≥ 10 bit periods later.
- IDLE with empty=1: outputs hold their idle values indefinitely.
- Reset mid-frame:
  - the next edge forces all reset values;
  - the byte in flight is discarded and is not re-read, because it was already popped;
  - tx_out returns high immediately, so the line sees a truncated frame.
- Reset and empty=0 on the same edge: reset wins. No pop that edge.

## Structure

- Shared package `crem_uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- Sub-module `uart_tx_bit_timer`:
  - parameter CLKS_PER_BIT; inputs r_clk, r_rst, run; output bit_done, a 1-cycle pulse at terminal count;
  - counter clears when run=0.
- Top module holds the FSM, shift register, bit index (clog2(DATA_WIDTH) bits), parity latch and output registers.

## Test plan

- Reset and idle: hold empty=1 for 200 cycles after r_rst → tx_out=1, busy=0, r_inc=0 throughout.
- Single byte, no parity: CLKS_PER_BIT=4, par_en=0, rd_data=0xF1, empty low for one frame.
  - One r_inc pulse of 1 cycle.
  - Line reads 0,1,0,0,0,1,1,1,1,1, each 4 cycles.
  - busy high for exactly 40 cycles.
- Parity: rd_data=0xF1, par_en=1.
  - par_typ=0 → parity bit 1.
  - par_typ=1 → parity bit 0.
  - Frame length 44 cycles.
- Burst: FIFO model preloaded with 0xF1, 0xF9, 0xF5 and empty=0 until three pops have occurred.
  - Three contiguous frames, no idle cycles between them, busy continuously 1.
  - Exactly 3 r_inc pulses, each 40 cycles apart.
- Reset mid-frame: assert r_rst for 1 cycle during data bit 3.
  - Next edge gives tx_out=1, busy=0, state IDLE.
  - With empty=0, the next byte starts one cycle after reset deasserts.
- Mid-frame input changes: toggle par_en, par_typ and rd_data during DATA → transmitted bits and parity match the values latched at frame start.
